program_loader: RTL

Boot-time program loader between the UART RX FIFO and the instruction memory. It reads a length-prefixed binary image byte by byte from the FIFO and assembles little-endian instruction words of parametrisable width. It writes each word into instruction memory, then publishes the instruction count (`inst_num`) and releases the core with `core_start`. It generalises the fixed 32-bit, single-image load path: word width and memory depth are parameters, image length is range-checked, and illegal images raise an error flag.

---
 rtl/program_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time loader: pulls a length-prefixed little-endian image from the UART RX FIFO,
// assembles WORD_BYTES-wide words into instruction memory, then releases the core.
module program_loader #(
  parameter int WORD_BYTES  = 4,
  parameter int IMEM_ADDR_W = 10,
  parameter int MAX_WORDS   = 2**IMEM_ADDR_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     Empty,
  input  logic [7:0]               fifo_data_out,
  output logic                     RE_fifo,
  output logic                     imem_we,
  output logic [IMEM_ADDR_W-1:0]   imem_addr,
  output logic [8*WORD_BYTES-1:0]  imem_wdata,
  output logic [31:0]              inst_num,
  output logic                     core_start,
  output logic                     load_err,
  output logic                     busy
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BC_W   = (WORD_BYTES > 4) ? $clog2(WORD_BYTES) : 2;
  localparam int WC_W   = IMEM_ADDR_W + 1;

  typedef enum logic [1:0] {HDR, BODY, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic              armed;
  logic              vld_p1;
  logic [BC_W-1:0]   byte_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [23:0]       hdr_sh;
  logic [WORD_W-1:0] word_sh;
  logic [31:0]       hdr_full;
  logic [WORD_W-1:0] word_full;
  logic              hdr_last, body_last, hdr_bad, words_done, re;

  // New byte enters at the top so the first (least significant) byte ends up at bit 0.
  function automatic logic [WORD_W-1:0] shift_in_word(input logic [WORD_W-1:0] sh,
                                                      input logic [7:0] b);
    shift_in_word = (sh >> 8) | (WORD_W'(b) << (WORD_W - 8));
  endfunction

  assign hdr_full   = {fifo_data_out, hdr_sh};
  assign word_full  = shift_in_word(word_sh, fifo_data_out);
  assign hdr_last   = (state == HDR)  && vld_p1 && (byte_cnt == BC_W'(3));
  assign body_last  = (state == BODY) && vld_p1 && (byte_cnt == BC_W'(WORD_BYTES - 1));
  assign hdr_bad    = (hdr_full == 32'd0) || (hdr_full > 32'(MAX_WORDS));
  assign words_done = (32'(word_cnt) == inst_num);

  // armed keeps the strobe low in the first cycle out of reset
  always_comb begin
    state_nxt = state;
    re        = 1'b0;
    case (state)
      HDR: begin
        re = armed && !Empty && !vld_p1;
        if (hdr_last) state_nxt = hdr_bad ? ERR : BODY;
      end
      BODY: begin
        re = !Empty && !vld_p1 && !words_done;
        if (imem_we && words_done) state_nxt = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= HDR;
    else        state <= state_nxt;
  end

  // p0 -> p1: read strobe issued, byte arrives on fifo_data_out
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed      <= 1'b0;
      vld_p1     <= 1'b0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      inst_num   <= '0;
    end else begin
      armed   <= 1'b1;
      vld_p1  <= re;
      imem_we <= body_last;
      if (vld_p1 && (state == HDR || state == BODY))
        byte_cnt <= (hdr_last || body_last) ? '0 : byte_cnt + BC_W'(1);
      if (hdr_last && !hdr_bad)
        inst_num <= hdr_full;
      if (body_last) begin
        imem_addr  <= word_cnt[IMEM_ADDR_W-1:0];
        imem_wdata <= word_full;
        word_cnt   <= word_cnt + WC_W'(1);
      end
    end
  end

  // p1: byte sampled into the assembly registers
  always_ff @(posedge CLK) begin
    if (vld_p1) begin
      if (state == HDR) hdr_sh  <= hdr_full[31:8];
      else              word_sh <= word_full;
    end
  end

  assign RE_fifo    = re;
  assign core_start = (state == DONE);
  assign load_err   = (state == ERR);
  assign busy       = (state == HDR) || (state == BODY);

endmodule
